// File: rtl/video_mnist_frame_scheduler.sv
// Frame-level admission scheduler in front of the MNIST pipeline: admits or drops whole
// camera frames, applies staged parameters only at an admitted SOF, and counts admits/drops.
module video_mnist_frame_scheduler #(
    parameter int unsigned TUSER_WIDTH    = 1,
    parameter int unsigned TDATA_WIDTH    = 8,
    parameter int unsigned SKIP_WIDTH     = 4,
    parameter int unsigned INFLIGHT_WIDTH = 2,
    parameter int unsigned MAX_INFLIGHT   = 2,
    parameter int unsigned COUNTER_WIDTH  = 16,
    parameter logic [7:0]  INIT_TH        = 8'd127,
    parameter logic        INIT_INV       = 1'b0,
    parameter logic [7:0]  INIT_BLANK     = 8'd58
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      ctl_enable,
    input  logic [SKIP_WIDTH-1:0]     ctl_skip,
    input  logic                      ctl_update,
    input  logic [7:0]                in_param_th,
    input  logic                      in_param_inv,
    input  logic [7:0]                in_param_blank_num,
    output logic [7:0]                param_th,
    output logic                      param_inv,
    output logic [7:0]                param_blank_num,
    input  logic                      res_frame_done,
    output logic [1:0]                stat_state,
    output logic [INFLIGHT_WIDTH-1:0] stat_inflight,
    output logic [COUNTER_WIDTH-1:0]  stat_accept_count,
    output logic [COUNTER_WIDTH-1:0]  stat_drop_count,
    input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
    input  logic                      s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]    s_axi4s_tdata,
    input  logic                      s_axi4s_tvalid,
    output logic                      s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
    output logic                      m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
    output logic                      m_axi4s_tvalid,
    input  logic                      m_axi4s_tready
);

    localparam logic [INFLIGHT_WIDTH-1:0] MAX_INF = INFLIGHT_WIDTH'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_PASS     = 2'd2,
        ST_SKIP     = 2'd3
    } state_t;

    state_t                    state;
    logic [SKIP_WIDTH-1:0]     skip_cnt;
    logic [INFLIGHT_WIDTH-1:0] inflight;
    logic                      update_pending;

    logic sof;
    logic admit_ok;
    logic slot_free;
    logic fwd_sel;
    logic drop_sof;
    logic quit_sof;
    logic fwd_hs;
    logic admit_hs;
    logic done_dec;

    assign sof       = s_axi4s_tvalid & s_axi4s_tuser[0];
    assign admit_ok  = ctl_enable & (skip_cnt == '0) & (inflight < MAX_INF);
    assign slot_free = ~m_axi4s_tvalid | m_axi4s_tready;

    // Beat routing: forward (subject to the output slot) or discard (always accepted)
    always_comb begin
        fwd_sel  = 1'b0;
        drop_sof = 1'b0;
        quit_sof = 1'b0;
        case (state)
            ST_WAIT_SOF, ST_SKIP: begin
                if (sof && admit_ok) fwd_sel = 1'b1;
                else if (sof)        drop_sof = 1'b1;
            end
            ST_PASS: begin
                if (!sof)            fwd_sel  = 1'b1;
                else if (admit_ok)   fwd_sel  = 1'b1;
                else if (ctl_enable) drop_sof = 1'b1;
                else                 quit_sof = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_axi4s_tready = fwd_sel ? slot_free : 1'b1;
    assign fwd_hs         = fwd_sel & s_axi4s_tvalid & slot_free;
    assign admit_hs       = fwd_hs & sof;
    assign done_dec       = res_frame_done & (inflight != '0);
    assign stat_state     = state;
    assign stat_inflight  = inflight;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= ST_IDLE;
            skip_cnt          <= '0;
            inflight          <= '0;
            update_pending    <= 1'b0;
            stat_accept_count <= '0;
            stat_drop_count   <= '0;
            param_th          <= INIT_TH;
            param_inv         <= INIT_INV;
            param_blank_num   <= INIT_BLANK;
            m_axi4s_tvalid    <= 1'b0;
            m_axi4s_tuser     <= '0;
            m_axi4s_tlast     <= 1'b0;
            m_axi4s_tdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl_enable) begin
                        skip_cnt <= '0;
                        state    <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF, ST_SKIP: begin
                    if (admit_hs)                 state <= ST_PASS;
                    else if (drop_sof)            state <= ST_SKIP;
                    else if (!sof && !ctl_enable) state <= ST_IDLE;
                end
                ST_PASS: begin
                    if (drop_sof)      state <= ST_SKIP;
                    else if (quit_sof) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (drop_sof) begin
                skip_cnt        <= (skip_cnt == '0) ? '0 : skip_cnt - SKIP_WIDTH'(1);
                stat_drop_count <= stat_drop_count + COUNTER_WIDTH'(1);
            end

            // Parameters only ever change on an admitted SOF, so a frame never mixes settings
            if (admit_hs) begin
                skip_cnt          <= ctl_skip;
                stat_accept_count <= stat_accept_count + COUNTER_WIDTH'(1);
                if (update_pending || ctl_update) begin
                    param_th        <= in_param_th;
                    param_inv       <= in_param_inv;
                    param_blank_num <= in_param_blank_num;
                end
                update_pending <= 1'b0;
            end else if (ctl_update) begin
                update_pending <= 1'b1;
            end

            if (admit_hs && !done_dec)      inflight <= inflight + INFLIGHT_WIDTH'(1);
            else if (!admit_hs && done_dec) inflight <= inflight - INFLIGHT_WIDTH'(1);

            // Single output register slice
            if (fwd_hs) begin
                m_axi4s_tvalid <= 1'b1;
                m_axi4s_tuser  <= s_axi4s_tuser;
                m_axi4s_tlast  <= s_axi4s_tlast;
                m_axi4s_tdata  <= s_axi4s_tdata;
            end else if (m_axi4s_tready) begin
                m_axi4s_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_mnist_frame_scheduler.sv
// Bench for video_mnist_frame_scheduler: directed scenarios plus randomized frames checked
// against a frame-level admission model and an expected-beat queue.
module tb_video_mnist_frame_scheduler;

    localparam int MAXI = 2;
    localparam int FW   = 4;
    localparam int FH   = 2;
    localparam int NB   = FW * FH;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ctl_enable;
    logic [3:0]  ctl_skip;
    logic        ctl_update;
    logic [7:0]  in_param_th;
    logic        in_param_inv;
    logic [7:0]  in_param_blank_num;
    logic [7:0]  param_th;
    logic        param_inv;
    logic [7:0]  param_blank_num;
    logic        res_frame_done;
    logic [1:0]  stat_state;
    logic [1:0]  stat_inflight;
    logic [15:0] stat_accept_count;
    logic [15:0] stat_drop_count;
    logic [0:0]  s_axi4s_tuser;
    logic        s_axi4s_tlast;
    logic [7:0]  s_axi4s_tdata;
    logic        s_axi4s_tvalid;
    logic        s_axi4s_tready;
    logic [0:0]  m_axi4s_tuser;
    logic        m_axi4s_tlast;
    logic [7:0]  m_axi4s_tdata;
    logic        m_axi4s_tvalid;
    logic        m_axi4s_tready = 1'b1;

    video_mnist_frame_scheduler dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .ctl_enable         (ctl_enable),
        .ctl_skip           (ctl_skip),
        .ctl_update         (ctl_update),
        .in_param_th        (in_param_th),
        .in_param_inv       (in_param_inv),
        .in_param_blank_num (in_param_blank_num),
        .param_th           (param_th),
        .param_inv          (param_inv),
        .param_blank_num    (param_blank_num),
        .res_frame_done     (res_frame_done),
        .stat_state         (stat_state),
        .stat_inflight      (stat_inflight),
        .stat_accept_count  (stat_accept_count),
        .stat_drop_count    (stat_drop_count),
        .s_axi4s_tuser      (s_axi4s_tuser),
        .s_axi4s_tlast      (s_axi4s_tlast),
        .s_axi4s_tdata      (s_axi4s_tdata),
        .s_axi4s_tvalid     (s_axi4s_tvalid),
        .s_axi4s_tready     (s_axi4s_tready),
        .m_axi4s_tuser      (m_axi4s_tuser),
        .m_axi4s_tlast      (m_axi4s_tlast),
        .m_axi4s_tdata      (m_axi4s_tdata),
        .m_axi4s_tvalid     (m_axi4s_tvalid),
        .m_axi4s_tready     (m_axi4s_tready)
    );

    always #5 aclk = ~aclk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    bit         bp = 1'b0;
    bit         gap_en = 1'b0;

    // Frame-level reference model state
    int         md_skip;
    int         md_inflight;
    int         md_accept;
    int         md_drop;
    bit         md_pending;
    logic [7:0] md_th;
    logic       md_inv;
    logic [7:0] md_blank;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_skip = 0; md_inflight = 0; md_accept = 0; md_drop = 0; md_pending = 1'b0;
        md_th = 8'd127; md_inv = 1'b0; md_blank = 8'd58;
    endtask

    // Admission decision for a whole frame, taken at its SOF
    task automatic model_sof(input bit upd, output bit adm);
        adm = 1'b0;
        if (upd) md_pending = 1'b1;
        if (ctl_enable) begin
            if (md_skip == 0 && md_inflight < MAXI) begin
                adm = 1'b1;
                md_skip = int'(ctl_skip);
                md_inflight++;
                md_accept++;
                if (md_pending) begin
                    md_th = in_param_th; md_inv = in_param_inv; md_blank = in_param_blank_num;
                end
                md_pending = 1'b0;
            end else begin
                md_drop++;
                if (md_skip > 0) md_skip--;
            end
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_accept"}, 32'(stat_accept_count), 32'(16'(md_accept)));
        check({tag, "_drop"}, 32'(stat_drop_count), 32'(16'(md_drop)));
        check({tag, "_inflight"}, 32'(stat_inflight), 32'(md_inflight));
        check({tag, "_params"}, 32'({param_th, param_inv, param_blank_num}),
              32'({md_th, md_inv, md_blank}));
    endtask

    task automatic send_beat(input logic sof, input logic last, input logic [7:0] d,
                             input bit fwd, input bit upd);
        int t;
        t = 0;
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = sof;
        s_axi4s_tlast  = last;
        s_axi4s_tdata  = d;
        ctl_update     = upd;
        forever begin
            @(negedge aclk);
            if (s_axi4s_tready) break;
            t++;
            if (t > 500) break;
        end
        if (fwd) check("fwd_accept_timeout", 32'(t > 500), 32'd0);
        else     check("discard_stall_cycles", 32'(t), 32'd0);
        if (fwd && t <= 500) exp_q.push_back({sof, last, d});
        @(posedge aclk); #1;
        s_axi4s_tvalid = 1'b0;
        ctl_update     = 1'b0;
        if (fwd && t <= 500)
            check("latency1", 32'({m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}),
                  32'({1'b1, sof, last, d}));
    endtask

    task automatic send_frame(input int upd_at, input int dis_at, output bit adm);
        logic [7:0] d;
        model_sof(upd_at == 0, adm);
        for (int i = 0; i < NB; i++) begin
            if (i == dis_at) ctl_enable = 1'b0;
            d = 8'($urandom);
            send_beat(i == 0, (i % FW) == FW - 1, d, adm, i == upd_at);
            if (i == 0 && adm)
                check("params_after_sof", 32'({param_th, param_inv, param_blank_num}),
                      32'({md_th, md_inv, md_blank}));
            if (gap_en) repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
        end
        if (upd_at > 0) md_pending = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        check_stats("frame_end");
    endtask

    task automatic set_enable(input logic v);
        if (v && !ctl_enable) md_skip = 0;
        ctl_enable = v;
        repeat (2) begin @(posedge aclk); #1; end
    endtask

    task automatic pulse_done();
        res_frame_done = 1'b1;
        @(posedge aclk); #1;
        res_frame_done = 1'b0;
        if (md_inflight > 0) md_inflight--;
        check("inflight_after_done", 32'(stat_inflight), 32'(md_inflight));
    endtask

    task automatic drain();
        bp = 1'b0;
        repeat (6) begin @(posedge aclk); #1; end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge aclk) begin
        #1;
        m_axi4s_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: order/content against expected queue, and stability while stalled
    logic [9:0] prev_beat;
    bit         prev_stall = 1'b0;
    always @(negedge aclk) begin : mon
        logic [9:0] cur;
        logic [9:0] e;
        cur = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("m_stable_while_stalled", 32'({m_axi4s_tvalid, cur}), 32'({1'b1, prev_beat}));
            if (m_axi4s_tvalid && m_axi4s_tready) begin
                check("m_beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_beat_data", 32'(cur), 32'(e));
                end
            end
            prev_stall = m_axi4s_tvalid && !m_axi4s_tready;
            prev_beat  = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit adm;
        aresetn = 1'b0; ctl_enable = 1'b0; ctl_skip = 4'd0; ctl_update = 1'b0;
        in_param_th = 8'd127; in_param_inv = 1'b0; in_param_blank_num = 8'd58;
        res_frame_done = 1'b0;
        s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = 8'd0; s_axi4s_tvalid = 1'b0;
        model_reset();
        repeat (3) begin @(posedge aclk); #1; end

        check("rst_state", 32'(stat_state), 32'd0);
        check("rst_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_axi4s_tready), 32'd1);
        check_stats("rst");
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Plain admission, no skip
        set_enable(1'b1);
        check("enable_state_wait_sof", 32'(stat_state), 32'd1);
        for (int f = 0; f < 3; f++) begin
            send_frame(-1, -1, adm);
            pulse_done();
        end
        check("t1_accept", 32'(stat_accept_count), 32'd3);
        check("t1_drop", 32'(stat_drop_count), 32'd0);

        // Decimation by 2
        ctl_skip = 4'd2;
        for (int f = 0; f < 6; f++) begin
            send_frame(-1, -1, adm);
            pulse_done();
        end
        check("t2_accept", 32'(stat_accept_count), 32'd5);
        check("t2_drop", 32'(stat_drop_count), 32'd4);

        // In-flight limit
        ctl_skip = 4'd0;
        for (int f = 0; f < 3; f++) send_frame(-1, -1, adm);
        check("t3_inflight_limit", 32'(stat_inflight), 32'd2);
        check("t3_drop", 32'(stat_drop_count), 32'd5);
        pulse_done();
        send_frame(-1, -1, adm);
        check("t3_accept_after_done", 32'(stat_accept_count), 32'd8);
        pulse_done();
        pulse_done();

        // Parameter update deferred to the next admitted SOF, and same-cycle update
        in_param_th = 8'd90; in_param_inv = 1'b1; in_param_blank_num = 8'd20;
        send_frame(3, -1, adm);
        check("t4_th_held", 32'(param_th), 32'd127);
        pulse_done();
        send_frame(-1, -1, adm);
        check("t4_th_applied", 32'(param_th), 32'd90);
        pulse_done();
        in_param_th = 8'd33;
        send_frame(0, -1, adm);
        check("t4_th_same_cycle", 32'(param_th), 32'd33);
        pulse_done();

        // Backpressure, then disable mid-frame
        bp = 1'b1; gap_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            send_frame(-1, -1, adm);
            pulse_done();
        end
        send_frame(-1, 4, adm);
        pulse_done();
        send_frame(-1, -1, adm);
        check("t5_idle_after_disable", 32'(stat_state), 32'd0);
        drain();
        set_enable(1'b1);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int r;
            int ua;
            r  = $urandom_range(0, 9);
            ua = -1;
            ctl_skip = 4'($urandom_range(0, 2));
            bp = ($urandom_range(0, 1) == 1);
            if (r == 0) begin
                set_enable(1'b0);
                send_frame(-1, -1, adm);
                check("rnd_idle_state", 32'(stat_state), 32'd0);
                set_enable(1'b1);
            end else begin
                if (r <= 3) begin
                    in_param_th = 8'($urandom);
                    in_param_inv = 1'($urandom);
                    in_param_blank_num = 8'($urandom);
                    ua = $urandom_range(0, NB - 1);
                end
                send_frame(ua, -1, adm);
            end
            if ($urandom_range(0, 2) != 0) pulse_done();
        end
        drain();
        gap_en = 1'b0;

        // Asynchronous reset mid-frame with a beat held on the output
        set_enable(1'b0);
        send_frame(-1, -1, adm);
        set_enable(1'b1);
        pulse_done();
        pulse_done();
        ctl_skip = 4'd0;
        model_sof(1'b0, adm);
        for (int i = 0; i < 3; i++) send_beat(i == 0, 1'b0, 8'($urandom), adm, 1'b0);
        check("rst_pre_m_tvalid", 32'(m_axi4s_tvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        check("rst_mid_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
        check("rst_mid_s_tready", 32'(s_axi4s_tready), 32'd1);
        check("rst_mid_state", 32'(stat_state), 32'd0);
        check_stats("rst_mid");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        send_frame(-1, -1, adm);
        check("rst_recover_accept", 32'(stat_accept_count), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_mnist_frame_scheduler.md
# video_mnist_frame_scheduler

Frame-level scheduler placed in front of the MNIST segmentation/classification pipeline (binarizer, conv, classification/segmentation, max-count). It admits or drops whole video frames from the camera AXI4-Stream under software enable, a frame-decimation ratio and an in-flight limit. It applies binarizer and blank parameter updates only at the start of an admitted frame, so a frame is never processed with mixed settings. It also keeps admit/drop statistics.

## Interface
- TUSER_WIDTH, 1, stream tuser width; bit 0 = start of frame (SOF)
- TDATA_WIDTH, 8, pixel width
- SKIP_WIDTH, 4, decimation counter width
- INFLIGHT_WIDTH, 2, in-flight counter width
- MAX_INFLIGHT, 2, max admitted frames not yet reported done (1..2^INFLIGHT_WIDTH-1)
- COUNTER_WIDTH, 16, statistics counter width
- INIT_TH / INIT_INV / INIT_BLANK, 127 / 0 / 58, reset values of applied parameters

Ports:
- aclk  in  1  clock; single clock domain
- aresetn  in  1  asynchronous, active-low reset
- ctl_enable  in  1  level; admit frames while 1
- ctl_skip  in  SKIP_WIDTH  drop N frames after each admitted frame
- ctl_update  in  1  pulse; request parameter update
- in_param_th, in_param_inv, in_param_blank_num  in  8/1/8  staged parameters
- param_th, param_inv, param_blank_num  out  8/1/8  applied parameters to pipeline
- res_frame_done  in  1  pulse; one admitted frame fully emitted by the max-count stage
- stat_state  out  2  FSM state
- stat_inflight  out  INFLIGHT_WIDTH  in-flight frame count
- stat_accept_count, stat_drop_count  out  COUNTER_WIDTH  wrapping counters
- s_axi4s_tuser/tlast/tdata/tvalid/tready  slave stream from camera
- m_axi4s_tuser/tlast/tdata/tvalid/tready  master stream to binarizer

## Operation
- SOF beat = s_tvalid & s_tuser[0]. Admit condition at SOF: ctl_enable & skip_cnt==0 & inflight<MAX_INFLIGHT.
- States: IDLE=0, WAIT_SOF=1, PASS=2, SKIP=3.
- IDLE: discard all beats (s_tready=1). If ctl_enable=1: skip_cnt<=0 and go to WAIT_SOF.
- WAIT_SOF / SKIP: discard non-SOF beats.
  - SOF with admit: forward the beat, go to PASS.
  - SOF without admit: discard, go to SKIP. skip_cnt decrements, saturating at 0. drop_count++.
  - ctl_enable=0 with no SOF: go to IDLE.
- PASS: forward all beats.
  - SOF with admit: forward, stay in PASS.
  - SOF with ctl_enable=1 and no admit: discard, go to SKIP, drop_count++.
  - SOF with ctl_enable=0: discard, go to IDLE. No drop count.
  - Mid-frame disable never truncates a frame.
- On admitted SOF handshake:
  - skip_cnt<=ctl_skip; inflight++; accept_count++.
  - If update_pending or ctl_update in the same cycle: param_* <= in_param_* sampled in that cycle, update_pending cleared.
- ctl_update sets update_pending. Parameters never change except at an admitted SOF.
- inflight: +1 on admitted SOF, −1 on res_frame_done. Both in one cycle: net 0. −1 at 0 is ignored.
- Counters wrap modulo 2^COUNTER_WIDTH.

## Timing
- Output is a single register slice. Forwarded beat appears on m_* 1 cycle after the s handshake. Full throughput with m_tready=1.
- s_tready:
  - Forwarding (PASS non-SOF, or admitting SOF): s_tready = ~m_tvalid | m_tready.
  - Discarding: s_tready=1.
  - Admit decision is combinational from registered state and the current inputs.
- m_* hold stable while m_tvalid & ~m_tready.
- Statistics and params update 1 cycle after the causing handshake. stat_state reflects the registered state.
- Reset (asynchronous, any time including mid-frame):
  - State=IDLE, m_tvalid=0, s_tready=1, inflight=0, skip_cnt=0, counters=0, update_pending=0.
  - param_th=INIT_TH, param_inv=INIT_INV, param_blank_num=INIT_BLANK.
  - The partial frame is abandoned. Downstream recovers on the next SOF.

## Test plan
- Enable with ctl_skip=0 and 3 frames of 4×2 pixels, res_frame_done after each frame: all 24 beats forwarded in order with latency 1. accept_count=3, drop_count=0.
- ctl_skip=2 with 6 frames: frames 0 and 3 forwarded, frames 1, 2, 4, 5 discarded with s_tready=1. accept_count=2, drop_count=4.
- MAX_INFLIGHT=2, res_frame_done withheld, 3 frames: first 2 admitted, 3rd dropped, stat_inflight=2. A res_frame_done pulse lets the 4th frame be admitted.
- ctl_update with in_param_th=90 mid-frame: param_th stays 127 until the next admitted SOF, then 90 one cycle later. ctl_update on the same cycle as an admitted SOF is applied at that SOF.
- Random m_tready backpressure (50%) in PASS: no beat lost or duplicated, m_* stable while stalled. Clear ctl_enable mid-frame: frame completes, next SOF discarded, state=IDLE.
- aresetn asserted mid-frame with m_tvalid=1: m_tvalid=0 immediately and all outputs at reset values. After release and enable, the next full frame is forwarded correctly.
